// File: rtl/axi_wr_phase_guard_pkg.sv
// Shared types for the AXI write-phase watchdog: per-slot state and the
// phase encoding reported alongside a latched timeout.
package axi_wr_phase_guard_pkg;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        WAIT_W = 2'd1,
        WAIT_B = 2'd2
    } slot_state_e;

    localparam logic PHASE_AW_W = 1'b0;
    localparam logic PHASE_W_B  = 1'b1;

    function automatic logic phase_of(slot_state_e s);
        return (s == WAIT_B) ? PHASE_W_B : PHASE_AW_W;
    endfunction

endpackage

// File: rtl/wr_phase_slot.sv
// One tracked write transaction: lifecycle state, AXI ID and a down-counter
// that is reloaded on every phase entry and flags a timeout on a tick at zero.
module wr_phase_slot
    import axi_wr_phase_guard_pkg::*;
#(
    parameter int IdWidth  = 4,
    parameter int CntWidth = 10
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                flush,
    input  logic                alloc,
    input  logic                alloc_wb,
    input  logic [IdWidth-1:0]  alloc_id,
    input  logic                wlast_hit,
    input  logic                b_hit,
    input  logic                tick,
    input  logic [CntWidth-1:0] budget_aw_w,
    input  logic [CntWidth-1:0] budget_w_b,
    output slot_state_e         state,
    output logic [IdWidth-1:0]  id,
    output logic                timeout
);

    typedef struct packed {
        slot_state_e         state;
        logic [IdWidth-1:0]  id;
        logic [CntWidth-1:0] cnt;
    } slot_t;

    slot_t q;

    // The top guarantees alloc, wlast_hit and b_hit are mutually exclusive
    // for a slot, so the priority order here only matters against tick.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush) begin
            q <= '0;
        end else if (alloc) begin
            q.state <= alloc_wb ? WAIT_B : WAIT_W;
            q.id    <= alloc_id;
            q.cnt   <= alloc_wb ? budget_w_b : budget_aw_w;
        end else if (wlast_hit) begin
            q.state <= WAIT_B;
            q.cnt   <= budget_w_b;
        end else if (b_hit) begin
            q.state <= FREE;
            q.cnt   <= '0;
        end else if (tick && q.state != FREE && q.cnt != '0) begin
            q.cnt <= q.cnt - 1'b1;
        end
    end

    assign state   = q.state;
    assign id      = q.id;
    assign timeout = tick && (q.state != FREE) && (q.cnt == '0);

endmodule

// File: rtl/axi_wr_phase_guard.sv
// Passive AXI4 write-channel watchdog: tracks each outstanding write in a slot
// and times AW->last W and last W->B separately, latching the first offender.
module axi_wr_phase_guard
    import axi_wr_phase_guard_pkg::*;
#(
    parameter int NumSlots     = 8,
    parameter int IdWidth      = 4,
    parameter int CntWidth     = 10,
    parameter int PrescalerDiv = 1
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        aw_valid_i,
    input  logic                        aw_ready_i,
    input  logic [IdWidth-1:0]          aw_id_i,
    input  logic                        w_valid_i,
    input  logic                        w_ready_i,
    input  logic                        w_last_i,
    input  logic                        b_valid_i,
    input  logic                        b_ready_i,
    input  logic [IdWidth-1:0]          b_id_i,
    input  logic [CntWidth-1:0]         budget_aw_w_i,
    input  logic [CntWidth-1:0]         budget_w_b_i,
    input  logic                        reset_clear_i,
    output logic                        reset_req_o,
    output logic                        irq_o,
    output logic [IdWidth-1:0]          timeout_id_o,
    output logic                        timeout_phase_o,
    output logic                        overflow_o,
    output logic                        unexpected_b_o,
    output logic                        full_o,
    output logic [$clog2(NumSlots):0]   outstanding_o
);

    localparam int PtrW = $clog2(NumSlots);
    localparam int PreW = (PrescalerDiv > 1) ? $clog2(PrescalerDiv) : 1;

    // Prescaler: first tick lands PrescalerDiv cycles after reset release.
    logic [PreW-1:0] pre_cnt;
    logic            tick;

    assign tick = (pre_cnt == PreW'(PrescalerDiv - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i)     pre_cnt <= '0;
        else if (tick) pre_cnt <= '0;
        else           pre_cnt <= pre_cnt + 1'b1;
    end

    function automatic logic [PtrW-1:0] lzc(input logic [NumSlots-1:0] v);
        logic [PtrW-1:0] idx;
        idx = '0;
        for (int i = NumSlots - 1; i >= 0; i--) begin
            if (v[i]) idx = PtrW'(i);
        end
        return idx;
    endfunction

    logic [PtrW-1:0]       tail, wptr, head;
    logic [PtrW:0]         early, outstanding;
    slot_state_e           slot_state [NumSlots];
    logic [IdWidth-1:0]    slot_id    [NumSlots];
    logic [NumSlots-1:0]   to_vec, b_match, b_rot;
    logic [2*NumSlots-1:0] b_dbl;
    logic [PtrW-1:0]       b_slot, to_idx;
    logic aw_hs, wl_hs, b_hs, tail_free, alloc, alloc_wb;
    logic wl_to_slot, wl_at_tail, b_free, early_sat;

    assign aw_hs      = aw_valid_i && aw_ready_i && !reset_clear_i;
    assign wl_hs      = w_valid_i && w_ready_i && w_last_i && !reset_clear_i;
    assign b_hs       = b_valid_i && b_ready_i && !reset_clear_i;
    assign tail_free  = (slot_state[tail] == FREE);
    assign alloc      = aw_hs && tail_free;
    assign wl_to_slot = wl_hs && (wptr != tail);
    assign wl_at_tail = wl_hs && (wptr == tail);
    // A last beat with no WAIT_W slot is data that outran its AW.
    assign alloc_wb   = alloc && ((early != '0) || wl_at_tail);
    assign early_sat  = wl_at_tail && !alloc_wb && (early == (PtrW+1)'(NumSlots));

    always_comb begin
        b_match = '0;
        for (int i = 0; i < NumSlots; i++) begin
            b_match[i] = (slot_state[i] == WAIT_B) && (slot_id[i] == b_id_i);
        end
    end

    // Rotate so bit 0 is the oldest slot; same-ID responses return in order.
    assign b_dbl  = {b_match, b_match};
    assign b_rot  = b_dbl[head +: NumSlots];
    assign b_slot = head + lzc(b_rot);
    assign b_free = b_hs && (b_match != '0);
    assign to_idx = lzc(to_vec);

    for (genvar g = 0; g < NumSlots; g++) begin : g_slot
        wr_phase_slot #(
            .IdWidth  (IdWidth),
            .CntWidth (CntWidth)
        ) u_slot (
            .clk_i       (clk_i),
            .rst_i       (rst_i),
            .flush       (reset_clear_i),
            .alloc       (alloc && (tail == PtrW'(g))),
            .alloc_wb    (alloc_wb),
            .alloc_id    (aw_id_i),
            .wlast_hit   (wl_to_slot && (wptr == PtrW'(g))),
            .b_hit       (b_free && (b_slot == PtrW'(g))),
            .tick        (tick),
            .budget_aw_w (budget_aw_w_i),
            .budget_w_b  (budget_w_b_i),
            .state       (slot_state[g]),
            .id          (slot_id[g]),
            .timeout     (to_vec[g])
        );
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || reset_clear_i) begin
            tail            <= '0;
            wptr            <= '0;
            head            <= '0;
            early           <= '0;
            outstanding     <= '0;
            reset_req_o     <= 1'b0;
            timeout_id_o    <= '0;
            timeout_phase_o <= 1'b0;
            overflow_o      <= 1'b0;
            unexpected_b_o  <= 1'b0;
        end else begin
            if (alloc) tail <= tail + 1'b1;
            // Early allocation only happens with wptr == tail, so wptr follows tail.
            if (wl_to_slot || alloc_wb) wptr <= wptr + 1'b1;
            if (slot_state[head] == FREE && outstanding != '0) head <= head + 1'b1;

            if (wl_at_tail && !alloc_wb && !early_sat) early <= early + 1'b1;
            else if (alloc_wb && !wl_at_tail)          early <= early - 1'b1;

            if (alloc && !b_free)      outstanding <= outstanding + 1'b1;
            else if (b_free && !alloc) outstanding <= outstanding - 1'b1;

            if ((aw_hs && !tail_free) || early_sat) overflow_o <= 1'b1;
            if (b_hs && !b_free) unexpected_b_o <= 1'b1;

            if (!reset_req_o && to_vec != '0) begin
                reset_req_o     <= 1'b1;
                timeout_id_o    <= slot_id[to_idx];
                timeout_phase_o <= phase_of(slot_state[to_idx]);
            end
        end
    end

    assign full_o        = !tail_free;
    assign outstanding_o = outstanding;
    assign irq_o         = reset_req_o || overflow_o || unexpected_b_o;

endmodule

// File: tb/tb_axi_wr_phase_guard.sv
// Cycle-table bench for axi_wr_phase_guard (4 slots, tick every cycle): each
// row is one cycle of stimulus plus the outputs expected after that edge.
module tb_axi_wr_phase_guard;

    localparam int NS = 4;
    localparam int IW = 4;
    localparam int CW = 10;

    logic clk = 1'b0;
    logic rst;
    logic aw_valid, aw_ready, w_valid, w_ready, w_last, b_valid, b_ready, clr;
    logic [IW-1:0] aw_id, b_id;
    logic [CW-1:0] baw, bwb;
    logic reset_req, irq, tphase, ovf, unx, full;
    logic [IW-1:0] tid;
    logic [$clog2(NS):0] outs;

    always #5 clk = ~clk;

    axi_wr_phase_guard #(
        .NumSlots(NS), .IdWidth(IW), .CntWidth(CW), .PrescalerDiv(1)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .aw_valid_i(aw_valid), .aw_ready_i(aw_ready), .aw_id_i(aw_id),
        .w_valid_i(w_valid), .w_ready_i(w_ready), .w_last_i(w_last),
        .b_valid_i(b_valid), .b_ready_i(b_ready), .b_id_i(b_id),
        .budget_aw_w_i(baw), .budget_w_b_i(bwb), .reset_clear_i(clr),
        .reset_req_o(reset_req), .irq_o(irq), .timeout_id_o(tid),
        .timeout_phase_o(tphase), .overflow_o(ovf), .unexpected_b_o(unx),
        .full_o(full), .outstanding_o(outs)
    );

    // w: 0 = no beat, 1 = non-last beat, 2 = last beat; rdy = {aw, w, b}
    typedef struct {
        int awv, awid, w, bv, bid, clr, rdy, baw, bwb;
        int rr, tid, tph, ovf, unx, full, outs, idx;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cur_baw = 10;
    int   cur_bwb = 10;

    function automatic void add(int awv, int awid, int w, int bv, int bid, int c,
                                int rr, int t, int tph, int o, int u, int f,
                                int n, int rdy = 7);
        vec_t v;
        v.awv = awv; v.awid = awid; v.w = w; v.bv = bv; v.bid = bid; v.clr = c;
        v.rdy = rdy; v.baw = cur_baw; v.bwb = cur_bwb;
        v.rr = rr; v.tid = t; v.tph = tph; v.ovf = o; v.unx = u; v.full = f;
        v.outs = n; v.idx = tbl.size();
        tbl.push_back(v);
    endfunction

    function automatic void idle(int cnt, int rr, int t, int tph, int o, int u,
                                 int f, int n);
        for (int k = 0; k < cnt; k++) add(0, 0, 0, 0, 0, 0, rr, t, tph, o, u, f, n);
    endfunction

    function automatic void clear_row();
        add(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    task automatic chk(string nm, int row, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s row %0d: got %0d, expected %0d", nm, row, act, exp);
        end
    endtask

    task automatic check_row(vec_t e);
        chk("reset_req", e.idx, int'(reset_req), e.rr);
        chk("irq", e.idx, int'(irq), (e.rr | e.ovf | e.unx));
        chk("overflow", e.idx, int'(ovf), e.ovf);
        chk("unexpected_b", e.idx, int'(unx), e.unx);
        chk("full", e.idx, int'(full), e.full);
        chk("outstanding", e.idx, int'(outs), e.outs);
        if (e.rr != 0) begin
            chk("timeout_id", e.idx, int'(tid), e.tid);
            chk("timeout_phase", e.idx, int'(tphase), e.tph);
        end
    endtask

    task automatic drive(vec_t v);
        aw_valid = v.awv[0];  aw_ready = v.rdy[2];  aw_id = v.awid[IW-1:0];
        w_valid  = (v.w != 0); w_last = (v.w == 2); w_ready = v.rdy[1];
        b_valid  = v.bv[0];   b_ready = v.rdy[0];   b_id = v.bid[IW-1:0];
        clr      = v.clr[0];  baw = v.baw[CW-1:0];  bwb = v.bwb[CW-1:0];
    endtask

    initial begin
        vec_t e, z;
        z = '{default: 0};
        z.rdy = 7;
        rst = 1'b1;
        drive(z);

        // single write, both budgets 10; handshakes held off by ready first
        add(1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b011);
        add(1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        idle(3, 0, 0, 0, 0, 0, 0, 1);
        add(0, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3'b101);
        add(0, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        idle(4, 0, 0, 0, 0, 0, 0, 1);
        add(0, 0, 0, 1, 3, 0, 0, 0, 0, 0, 0, 0, 1, 3'b110);
        add(0, 0, 0, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0);

        // AW->W timeout, budget 5: non-last beats must not end the phase
        clear_row();
        cur_baw = 5;
        add(1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        for (int k = 0; k < 5; k++) add(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        idle(2, 1, 2, 0, 0, 0, 0, 1);
        add(1, 5, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);

        // budget 0 fires on the first tick after entry
        cur_baw = 0;
        add(1, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        idle(1, 1, 9, 0, 0, 0, 0, 1);
        clear_row();

        // W before AW, then AW with same-cycle last beat
        cur_baw = 10;
        add(0, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        add(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2);
        add(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1);
        add(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 5, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        add(0, 0, 0, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0);

        // early-last counter saturates at NumSlots
        clear_row();
        for (int k = 0; k < NS; k++) add(0, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 2, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);

        // out-of-order B over duplicate IDs
        clear_row();
        cur_baw = 20; cur_bwb = 20;
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        add(1, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2);
        add(1, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3);
        add(0, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3);
        add(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 2);
        add(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        add(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // fill all slots, then one more AW overflows
        clear_row();
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        add(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2);
        add(1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3);
        add(1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4);
        add(1, 4, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 4);

        // unexpected B with one write outstanding
        clear_row();
        cur_baw = 10; cur_bwb = 10;
        add(1, 6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        add(0, 0, 0, 1, 7, 0, 0, 0, 0, 0, 0, 0, 1, 3'b110);
        add(0, 0, 0, 1, 7, 0, 0, 0, 0, 0, 1, 0, 1);
        idle(1, 0, 0, 0, 0, 1, 0, 1);

        // B in the same cycle as its own last beat is unexpected
        clear_row();
        add(1, 8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        add(0, 0, 2, 1, 8, 0, 0, 0, 0, 0, 1, 0, 1);
        add(0, 0, 0, 1, 8, 0, 0, 0, 0, 0, 1, 0, 0);

        // slots 1 and 2 time out together; lowest index wins and stays latched
        clear_row();
        cur_bwb = 20;
        add(1, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        add(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cur_baw = 3;
        add(1, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        cur_baw = 2;
        add(1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2);
        idle(2, 0, 0, 0, 0, 0, 0, 2);
        idle(1, 1, 4, 0, 0, 0, 0, 2);
        cur_bwb = 0;
        add(0, 0, 2, 0, 0, 0, 1, 4, 0, 0, 0, 0, 2);
        idle(2, 1, 4, 0, 0, 0, 0, 2);
        clear_row();

        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_reset_req", -1, int'(reset_req), 0);
        chk("rst_irq", -1, int'(irq), 0);
        chk("rst_timeout_id", -1, int'(tid), 0);
        chk("rst_timeout_phase", -1, int'(tphase), 0);
        chk("rst_overflow", -1, int'(ovf), 0);
        chk("rst_unexpected_b", -1, int'(unx), 0);
        chk("rst_full", -1, int'(full), 0);
        chk("rst_outstanding", -1, int'(outs), 0);

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_row(e);
            end
            drive(tbl[i]);
            exp_q.push_back(tbl[i]);
        end
        @(negedge clk);
        drive(z);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_row(e);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
